// File: rtl/conv_pkg.sv
// Shared types, constants and the output saturation helper for the 3x3 MAC unit.
package conv_pkg;

   localparam int unsigned PIX_W  = 8;
   localparam int unsigned WT_W   = 8;
   localparam int unsigned TAPS   = 9;
   localparam int unsigned RES_W  = 18;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned PROD_W = PIX_W + WT_W + 1;  // 9b zero-extended pixel x 8b weight
   localparam int unsigned ROW_W  = PROD_W + 2;        // sum of three products
   localparam int unsigned SUM_W  = ROW_W + 2;         // sum of three row sums

   localparam int RES_MAX = 131071;
   localparam int RES_MIN = -131072;

   typedef logic        [PIX_W-1:0]  pixel_t;
   typedef logic signed [WT_W-1:0]   weight_t;
   typedef logic signed [PROD_W-1:0] product_t;
   typedef logic signed [ROW_W-1:0]  row_sum_t;
   typedef logic signed [SUM_W-1:0]  sum_t;
   typedef logic signed [RES_W-1:0]  result_t;

   // Clamp the full-precision sum into the signed result range.
   function automatic result_t sat_res(input sum_t i_sum);
      result_t v;
      if (i_sum > sum_t'(RES_MAX)) begin
         v = result_t'(RES_MAX);
      end else if (i_sum < sum_t'(RES_MIN)) begin
         v = result_t'(RES_MIN);
      end else begin
         v = result_t'(i_sum);
      end
      return v;
   endfunction

endpackage

// File: rtl/conv_row_mac.sv
// One kernel row: three pixel x weight products (S1) reduced to a registered row sum (S2).
module conv_row_mac
   import conv_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_s1_en,
   input  logic                  i_s2_en,
   input  logic [3*PIX_W-1:0]    i_pix,
   input  logic [3*WT_W-1:0]     i_wt,
   output row_sum_t              o_row_sum
);

   product_t w_prod [3];
   product_t r_prod [3];
   row_sum_t w_row_sum;
   row_sum_t r_row_sum;

   // Products: pixel is unsigned, so it gets a zero sign bit before the signed multiply
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         w_prod[i] = product_t'($signed({1'b0, i_pix[i*PIX_W +: PIX_W]}))
                   * product_t'($signed(i_wt[i*WT_W +: WT_W]));
      end
   end

   // Row reduction, sign-extended so the three-way sum cannot overflow
   always_comb begin
      w_row_sum = row_sum_t'(r_prod[0]) + row_sum_t'(r_prod[1]) + row_sum_t'(r_prod[2]);
   end

   // S1 product registers load on acceptance; S2 row sum advances whenever not stalled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prod    <= '{default: '0};
         r_row_sum <= '0;
      end else begin
         if (i_s1_en) begin
            r_prod <= w_prod;
         end
         if (i_s2_en) begin
            r_row_sum <= w_row_sum;
         end
      end
   end

   assign o_row_sum = r_row_sum;

endmodule

// File: rtl/conv3x3_mac_unit.sv
// 3x3 convolution MAC: three row MACs (S1+S2), final sum, saturation and result handshake (S3).
// Optional build macro CONV_MAC_RELU_EN clamps negative saturated results to zero.
module conv3x3_mac_unit
   import conv_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [TAPS*PIX_W-1:0]  window,
   input  logic                   win_valid,
   output logic                   win_ready,
   input  logic                   wt_load,
   input  logic [TAPS*WT_W-1:0]   wt_data,
   output logic [RES_W-1:0]       result,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [CNT_W-1:0]       res_count
);

   logic [TAPS*WT_W-1:0] r_kernel;
   logic                 r_v1;
   logic                 r_v2;
   logic                 r_res_valid;
   result_t              r_result;
   logic [CNT_W-1:0]     r_count;

   logic     w_stall;
   logic     w_adv;
   logic     w_accept;
   row_sum_t w_row_sum [3];
   sum_t     w_sum;
   result_t  w_sat;
   result_t  w_res;

   // Global stall: a presented result that downstream refuses freezes the whole pipe
   always_comb begin
      w_stall  = r_res_valid & ~res_ready;
      w_adv    = ~w_stall;
      w_accept = win_valid & w_adv;
   end

   // Row MACs read the kernel register before this edge's load, so a same-cycle load is not seen
   for (genvar g = 0; g < 3; g++) begin : g_row
      conv_row_mac u_row (
         .clk       (clk),
         .rst       (rst),
         .i_s1_en   (w_accept),
         .i_s2_en   (w_adv),
         .i_pix     (window[g*3*PIX_W +: 3*PIX_W]),
         .i_wt      (r_kernel[g*3*WT_W +: 3*WT_W]),
         .o_row_sum (w_row_sum[g])
      );
   end

   // Final sum and saturation, with optional ReLU
   always_comb begin
      w_sum = sum_t'(w_row_sum[0]) + sum_t'(w_row_sum[1]) + sum_t'(w_row_sum[2]);
      w_sat = sat_res(w_sum);
`ifdef CONV_MAC_RELU_EN
      w_res = w_sat[RES_W-1] ? '0 : w_sat;
`else
      w_res = w_sat;
`endif
   end

   // Kernel register loads whenever requested, independent of stall
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_kernel <= '0;
      end else if (wt_load) begin
         r_kernel <= wt_data;
      end
   end

   // Stage valids and S3 result; result only changes when a valid sum arrives
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_v1        <= 1'b0;
         r_v2        <= 1'b0;
         r_res_valid <= 1'b0;
         r_result    <= '0;
      end else if (w_adv) begin
         r_v1        <= w_accept;
         r_v2        <= r_v1;
         r_res_valid <= r_v2;
         if (r_v2) begin
            r_result <= w_res;
         end
      end
   end

   // Count results taken by downstream; wraps naturally
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (r_res_valid && res_ready) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign win_ready = w_adv;
   assign result    = r_result;
   assign res_valid = r_res_valid;
   assign res_count = r_count;

endmodule

// File: tb/tb_conv3x3_mac_unit.sv
// Scoreboard bench for conv3x3_mac_unit: driver pushes model results, monitor pops on transfer.
module tb_conv3x3_mac_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [71:0] window;
   logic        win_valid;
   logic        win_ready;
   logic        wt_load;
   logic [71:0] wt_data;
   logic [17:0] result;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_count;

   always #5 clk = ~clk;

   conv3x3_mac_unit u_dut (
      .clk       (clk),
      .rst       (rst),
      .window    (window),
      .win_valid (win_valid),
      .win_ready (win_ready),
      .wt_load   (wt_load),
      .wt_data   (wt_data),
      .result    (result),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_count (res_count)
   );

   int          checks   = 0;
   int          failures = 0;
   logic [17:0] exp_q [$];
   logic [71:0] model_kern;
   logic [15:0] exp_count;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic logic [71:0] rand72();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[71:0];
   endfunction

   // Reference: plain integer dot product, clamp, optional ReLU
   function automatic logic [17:0] model(input logic [71:0] w, input logic [71:0] k);
      int s;
      s = 0;
      for (int i = 0; i < 9; i++) begin
         logic [7:0]        p;
         logic signed [7:0] c;
         p = w[8*i +: 8];
         c = k[8*i +: 8];
         s += int'(p) * int'(c);
      end
      if (s > 131071) s = 131071;
      if (s < -131072) s = -131072;
`ifdef CONV_MAC_RELU_EN
      if (s < 0) s = 0;
`endif
      return s[17:0];
   endfunction

   // One cycle of stimulus, applied mid-cycle; acceptance decided from the settled win_ready
   task automatic step(input logic v, input logic [71:0] w, input logic ld,
                       input logic [71:0] wd, input logic rr, output logic acc, output logic rdy);
      win_valid = v;
      window    = w;
      wt_load   = ld;
      wt_data   = wd;
      res_ready = rr;
      #1;
      rdy = win_ready;
      acc = v && win_ready;
      if (acc) exp_q.push_back(model(w, model_kern));
      if (ld) model_kern = wd;
      @(negedge clk);
   endtask

   task automatic send(input logic [71:0] w);
      logic acc, rdy;
      acc = 1'b0;
      for (int i = 0; i < 50 && !acc; i++) step(1'b1, w, 1'b0, '0, 1'b1, acc, rdy);
      chk("send_accepted", int'(acc), 1);
   endtask

   task automatic load(input logic [71:0] k);
      logic acc, rdy;
      step(1'b0, '0, 1'b1, k, 1'b1, acc, rdy);
   endtask

   task automatic drain();
      logic acc, rdy;
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) step(1'b0, '0, 1'b0, '0, 1'b1, acc, rdy);
      chk("drain_queue_empty", exp_q.size(), 0);
   endtask

   // Monitor: compares every transfer against the queue and checks hold behaviour
   initial begin : monitor
      logic        stalled;
      logic [17:0] held;
      logic [17:0] e;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            stalled = 1'b0;
            held    = '0;
         end else begin
            chk("res_count", int'(res_count), int'(exp_count));
            if (stalled) begin
               chk("stall_hold_valid", int'(res_valid), 1);
               chk("stall_hold_result", int'($signed(result)), int'($signed(held)));
            end
            if (!res_valid) chk("idle_hold_result", int'($signed(result)), int'($signed(held)));
            if (res_valid && res_ready) begin
               if (exp_q.size() == 0) begin
                  chk("spurious_result", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("result", int'($signed(result)), int'($signed(e)));
               end
               exp_count++;
            end
            stalled = res_valid && !res_ready;
            held    = result;
         end
      end
   end

   initial begin : driver
      logic        acc, rdy, pend_v;
      logic [71:0] pend_w, ones, ff, k;
      logic [7:0]  kb;
      int          n;
      rst = 1'b0; win_valid = 1'b0; window = '0; wt_load = 1'b0; wt_data = '0; res_ready = 1'b0;
      model_kern = '0;
      exp_count  = '0;
      ones = {9{8'h01}};
      ff   = {9{8'hFF}};

      // Reset held with random inputs
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         window = rand72(); win_valid = 1'($urandom_range(0, 1));
         wt_data = rand72(); wt_load = 1'($urandom_range(0, 1));
         res_ready = 1'($urandom_range(0, 1));
         #1;
         chk("rst_result", int'(result), 0);
         chk("rst_res_valid", int'(res_valid), 0);
         chk("rst_res_count", int'(res_count), 0);
         chk("rst_win_ready", int'(win_ready), 1);
      end
      @(negedge clk);
      rst = 1'b1; win_valid = 1'b0; wt_load = 1'b0; res_ready = 1'b1;
      @(negedge clk);
      send(rand72());  // kernel still zero -> 0
      drain();
      chk("zero_kernel_result", int'($signed(result)), 0);

      // Basic with latency
      load(ones);
      step(1'b1, ones, 1'b0, '0, 1'b1, acc, rdy);
      chk("basic_accept", int'(acc), 1);
      chk("lat_cycle1", int'(res_valid), 0);
      step(1'b0, '0, 1'b0, '0, 1'b1, acc, rdy);
      chk("lat_cycle2", int'(res_valid), 0);
      step(1'b0, '0, 1'b0, '0, 1'b1, acc, rdy);
      chk("lat_cycle3", int'(res_valid), 1);
      chk("basic_result", int'($signed(result)), 9);
      drain();

      // Saturation
      load({9{8'd127}});
      send(ff);
      drain();
      chk("sat_pos", int'($signed(result)), 131071);
      load({9{8'h80}});
      send(ff);
      drain();
`ifdef CONV_MAC_RELU_EN
      chk("sat_neg", int'($signed(result)), 0);
`else
      chk("sat_neg", int'($signed(result)), -131072);
`endif

      // Backpressure: six windows, downstream refuses in cycles 4..9
      load(ones);
      n = 0;
      for (int cyc = 0; cyc < 40 && !(n == 6 && exp_q.size() == 0); cyc++) begin
         kb = 8'(n + 1);
         step(n < 6, {9{kb}}, 1'b0, '0, !(cyc >= 4 && cyc <= 9), acc, rdy);
         if (cyc >= 4 && cyc <= 9) chk("bp_win_ready_low", int'(rdy), 0);
         if (cyc < 4) chk("bp_win_ready_high", int'(rdy), 1);
         if (acc) n++;
      end
      chk("bp_all_accepted", n, 6);
      chk("bp_all_delivered", exp_q.size(), 0);
      chk("bp_last_result", int'($signed(result)), 54);

      // Kernel swap in the acceptance cycle
      step(1'b1, ones, 1'b1, {9{8'd2}}, 1'b1, acc, rdy);
      chk("swap_accept_a", int'(acc), 1);
      step(1'b1, ones, 1'b0, '0, 1'b1, acc, rdy);
      chk("swap_accept_b", int'(acc), 1);
      step(1'b0, '0, 1'b0, '0, 1'b1, acc, rdy);
      chk("swap_old_kernel", int'($signed(result)), 9);
      step(1'b0, '0, 1'b0, '0, 1'b1, acc, rdy);
      chk("swap_new_kernel", int'($signed(result)), 18);
      drain();

      // Random traffic with occasional kernel loads
      pend_v = 1'b0;
      pend_w = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!pend_v && $urandom_range(0, 3) != 0) begin
            pend_v = 1'b1;
            pend_w = rand72();
         end
         k = rand72();
         step(pend_v, pend_w, $urandom_range(0, 9) == 0, k, $urandom_range(0, 3) != 0, acc, rdy);
         if (acc) pend_v = 1'b0;
      end
      drain();

      // Reset with two results in flight
      send(rand72());
      send(rand72());
      rst = 1'b0; win_valid = 1'b0;
      exp_q.delete();
      exp_count  = '0;
      model_kern = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, '0, 1'b0, '0, 1'b1, acc, rdy);
         chk("midrst_no_valid", int'(res_valid), 0);
      end
      chk("midrst_count", int'(res_count), 0);

      // Counter wrap
      n = 0;
      for (int cyc = 0; cyc < 70000 && n < 65535; cyc++) begin
         step(1'b1, '0, 1'b0, '0, 1'b1, acc, rdy);
         if (acc) n++;
      end
      drain();
      chk("count_ffff", int'(res_count), 65535);
      send(ones);
      drain();
      chk("count_wrap", int'(res_count), 0);

      step(1'b0, '0, 1'b0, '0, 1'b1, acc, rdy);
      chk("final_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
